// File: rtl/pew_array.sv
//==============================================================================
// Module   : pew_array
// Brief    : Per-channel debounced trigger to fixed-width pulse burst + cooldown.
// Revision : 1.0
//==============================================================================
`default_nettype none

module pew_array #(
    parameter int CHANNELS        = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int PULSE_CYCLES    = 500,
    parameter int GAP_CYCLES      = 500,
    parameter int BURST           = 3,
    parameter int COOLDOWN_CYCLES = 10000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [CHANNELS-1:0]   trigger,
    output logic [CHANNELS-1:0]   pew,
    output logic [CHANNELS-1:0]   busy,
    output logic [4*CHANNELS-1:0] status
);

    localparam int c_TMAX_PG = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int c_TMAX    = (c_TMAX_PG > COOLDOWN_CYCLES) ? c_TMAX_PG : COOLDOWN_CYCLES;
    localparam int c_DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_TW      = $clog2(c_TMAX + 1);
    localparam int c_BW      = $clog2(BURST + 1);

    localparam logic [c_DW-1:0] c_DEB_LAST   = c_DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TW-1:0] c_PULSE_LAST = c_TW'(PULSE_CYCLES - 1);
    localparam logic [c_TW-1:0] c_GAP_LAST   = c_TW'(GAP_CYCLES - 1);
    localparam logic [c_TW-1:0] c_COOL_LAST  = c_TW'(COOLDOWN_CYCLES - 1);
    localparam logic [c_BW-1:0] c_BURST_LAST = c_BW'(BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2,
        S_COOL  = 2'd3
    } state_t;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic            r_sync1;
        logic            r_sync2;
        logic            r_deb;
        logic            r_deb_q;
        logic [c_DW-1:0] r_deb_cnt;
        state_t          r_state;
        logic [c_TW-1:0] r_timer;
        logic [c_BW-1:0] r_pulses;
        logic            r_pew;
        logic            r_busy;
        logic [3:0]      r_status;
        logic            w_start;

        // deb only follows sync after DEBOUNCE_CYCLES consecutive disagreeing cycles
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_deb     <= 1'b0;
                r_deb_q   <= 1'b0;
                r_deb_cnt <= '0;
            end else begin
                r_sync1 <= trigger[g];
                r_sync2 <= r_sync1;
                r_deb_q <= r_deb;
                if (r_sync2 == r_deb) begin
                    r_deb_cnt <= '0;
                end else if (r_deb_cnt == c_DEB_LAST) begin
                    r_deb     <= r_sync2;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + c_DW'(1);
                end
            end
        end

        assign w_start = r_deb & ~r_deb_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state  <= S_IDLE;
                r_timer  <= '0;
                r_pulses <= '0;
                r_pew    <= 1'b0;
                r_busy   <= 1'b0;
                r_status <= 4'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start && en) begin
                            r_state  <= S_PULSE;
                            r_timer  <= '0;
                            r_pulses <= '0;
                            r_pew    <= 1'b1;
                            r_busy   <= 1'b1;
                        end
                    end
                    S_PULSE: begin
                        if (r_timer == c_PULSE_LAST) begin
                            r_timer <= '0;
                            r_pew   <= 1'b0;
                            if (r_pulses == c_BURST_LAST) begin
                                r_state  <= S_COOL;
                                r_status <= r_status + 4'd1;
                            end else begin
                                r_state  <= S_GAP;
                                r_pulses <= r_pulses + c_BW'(1);
                            end
                        end else begin
                            r_timer <= r_timer + c_TW'(1);
                        end
                    end
                    S_GAP: begin
                        if (r_timer == c_GAP_LAST) begin
                            r_timer <= '0;
                            r_state <= S_PULSE;
                            r_pew   <= 1'b1;
                        end else begin
                            r_timer <= r_timer + c_TW'(1);
                        end
                    end
                    S_COOL: begin
                        if (r_timer == c_COOL_LAST) begin
                            r_timer <= '0;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_timer <= r_timer + c_TW'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_timer <= '0;
                        r_pew   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end

        assign pew[g]          = r_pew;
        assign busy[g]         = r_busy;
        assign status[4*g +: 4] = r_status;
    end

endmodule

`default_nettype wire

// File: tb/tb_pew_array.sv
//==============================================================================
// Module   : tb_pew_array
// Brief    : Directed stimulus with a timeline model of pew_array, checked each cycle.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_pew_array;

    localparam int CH = 2;
    localparam int D  = 4;
    localparam int P  = 3;
    localparam int G  = 2;
    localparam int B  = 2;
    localparam int C  = 5;
    localparam int T_COOL_AT = B*P + (B-1)*G;
    localparam int T_TOTAL   = T_COOL_AT + C;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            en = 1'b1;
    logic [CH-1:0]   trigger = '0;
    logic [CH-1:0]   pew;
    logic [CH-1:0]   busy;
    logic [4*CH-1:0] status;

    int n_checks = 0;
    int n_errors = 0;

    pew_array #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P),
        .GAP_CYCLES(G), .BURST(B), .COOLDOWN_CYCLES(C)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .trigger(trigger), .pew(pew), .busy(busy), .status(status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a burst is a timeline indexed by t = cycles since leaving idle (-1 = idle).
    int m_t[CH]      = '{-1, -1};
    int m_run[CH]    = '{0, 0};
    int m_status[CH] = '{0, 0};
    bit m_s1[CH], m_s2[CH], m_deb[CH], m_debq[CH];

    function automatic bit model_pew(input int t);
        if (t < 0 || t >= T_COOL_AT) return 1'b0;
        return (t % (P + G)) < P;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit st;
        if (!rst_n) begin
            for (int ch = 0; ch < CH; ch++) begin
                m_t[ch] = -1; m_run[ch] = 0; m_status[ch] = 0;
                m_s1[ch] = 0; m_s2[ch] = 0; m_deb[ch] = 0; m_debq[ch] = 0;
            end
        end else begin
            for (int ch = 0; ch < CH; ch++) begin
                st = m_deb[ch] & ~m_debq[ch];
                if (m_t[ch] < 0) begin
                    if (st && en) m_t[ch] = 0;
                end else begin
                    m_t[ch]++;
                    if (m_t[ch] == T_COOL_AT) m_status[ch] = (m_status[ch] + 1) % 16;
                    if (m_t[ch] == T_TOTAL) m_t[ch] = -1;
                end
                m_debq[ch] = m_deb[ch];
                if (m_s2[ch] != m_deb[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == D) begin
                        m_deb[ch] = m_s2[ch];
                        m_run[ch] = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
                m_s2[ch] = m_s1[ch];
                m_s1[ch] = trigger[ch];
            end
        end
    end

    always @(negedge clk) begin
        for (int ch = 0; ch < CH; ch++) begin
            check($sformatf("model_pew[%0d]", ch), int'(pew[ch]), int'(model_pew(m_t[ch])));
            check($sformatf("model_busy[%0d]", ch), int'(busy[ch]), (m_t[ch] >= 0) ? 1 : 0);
            check($sformatf("model_status[%0d]", ch), int'(status[4*ch +: 4]), m_status[ch]);
        end
    end

    bit cp[CH][64];
    bit cb[CH][64];
    int cs[CH][64];

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int ch = 0; ch < CH; ch++) begin
                cp[ch][k] = pew[ch];
                cb[ch][k] = busy[ch];
                cs[ch][k] = int'(status[4*ch +: 4]);
            end
        end
    endtask

    function automatic int first_rise(input int ch, input int n);
        for (int k = 0; k < n; k++) if (cp[ch][k]) return k;
        return -1;
    endfunction

    function automatic int count_rises(input int ch, input int n);
        int r = 0;
        for (int k = 0; k < n; k++) if (cp[ch][k] && (k == 0 || !cp[ch][k-1])) r++;
        return r;
    endfunction

    function automatic int count_busy(input int ch, input int n);
        int r = 0;
        for (int k = 0; k < n; k++) if (cb[ch][k]) r++;
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] pat;
        int s_before;
        pat = 8'b1110_0111;

        #1 rst_n = 1'b0;
        idle(2);
        check("reset_pew", int'(pew), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_status", int'(status), 0);
        rst_n = 1'b1;
        idle(2);

        // Single burst on channel 0
        trigger[0] = 1'b1;
        capture(20);
        trigger[0] = 1'b0;
        check("single_first_rise", first_rise(0, 20), 6);
        for (int k = 0; k < 8; k++)
            check($sformatf("single_pattern[%0d]", k), int'(cp[0][6+k]), int'(pat[7-k]));
        check("single_busy_len", count_busy(0, 20), 13);
        check("single_status_before", cs[0][13], 0);
        check("single_status_after", cs[0][14], 1);
        check("single_ch1_pew", count_rises(1, 20), 0);
        check("single_ch1_busy", count_busy(1, 20), 0);
        idle(15);

        // Glitch on channel 1
        trigger[1] = 1'b1;
        idle(3);
        trigger[1] = 1'b0;
        capture(15);
        check("glitch_busy", count_busy(1, 15), 0);
        check("glitch_status", int'(status[7:4]), 0);

        // Retrigger toggling during a burst
        for (int k = 0; k < 40; k++) begin
            trigger[0] = (k < 18) ? (((k / 6) % 2) == 0) : 1'b0;
            @(negedge clk);
            cp[0][k] = pew[0];
            cb[0][k] = busy[0];
        end
        check("toggle_pulses", count_rises(0, 40), B);
        check("toggle_busy_len", count_busy(0, 40), 13);
        trigger[0] = 1'b1;
        capture(20);
        trigger[0] = 1'b0;
        check("new_edge_first_rise", first_rise(0, 20), 6);
        idle(15);

        // Held across cooldown
        trigger[0] = 1'b1;
        capture(40);
        trigger[0] = 1'b0;
        check("held_pulses", count_rises(0, 40), B);
        check("held_busy_len", count_busy(0, 40), 13);
        idle(15);

        // Disarmed
        en = 1'b0;
        trigger[0] = 1'b1;
        capture(20);
        trigger[0] = 1'b0;
        check("en0_busy", count_busy(0, 20), 0);
        idle(12);
        en = 1'b1;
        idle(2);

        // Enable dropped mid-burst
        s_before = int'(status[3:0]);
        trigger[0] = 1'b1;
        for (int k = 0; k < 25; k++) begin
            if (k == 8) en = 1'b0;
            @(negedge clk);
            cp[0][k] = pew[0];
        end
        trigger[0] = 1'b0;
        check("en_drop_pulses", count_rises(0, 25), B);
        check("en_drop_status", int'(status[3:0]), (s_before + 1) % 16);
        idle(12);
        en = 1'b1;
        idle(2);

        // 16 bursts on channel 1 wrap its status
        for (int i = 0; i < 16; i++) begin
            trigger[1] = 1'b1;
            idle(8);
            trigger[1] = 1'b0;
            idle(25);
            check($sformatf("wrap_status[%0d]", i), int'(status[7:4]), (i + 1) % 16);
        end

        // Asynchronous reset during GAP, released with trigger held
        trigger[0] = 1'b1;
        idle(10);
        check("pre_reset_pew", int'(pew[0]), 0);
        check("pre_reset_busy", int'(busy[0]), 1);
        check("pre_reset_status", int'(status[3:0]), 5);
        #1 rst_n = 1'b0;
        #1;
        check("async_pew", int'(pew), 0);
        check("async_busy", int'(busy), 0);
        check("async_status", int'(status), 0);
        idle(2);
        rst_n = 1'b1;
        capture(20);
        trigger[0] = 1'b0;
        check("post_reset_first_rise", first_rise(0, 20), 6);
        check("post_reset_busy_len", count_busy(0, 20), 13);
        idle(15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
